inst_fetch_q: RTL and testbench
===============================

Name: inst_fetch_q

Overview:
- Instruction fetch queue between the PC/instruction-ROM stage and the decode stage of the pipelined MIPS core.
- Captures each {pc, inst} pair returned while the chip enable is active and holds it in a small circular FIFO.
- Presents the oldest pair to decode with a valid/ready handshake, decoupling fetch from decode stalls.
- Supports a pipeline flush (branch/exception) that discards all queued instructions.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
ADDR_W, 32, instruction address width (InstAddrBus)
INST_W, 32, instruction word width (InstBus)

Ports:
clk  input  1  clock; one clock, all state updates on rising edge
rst  input  1  reset; asynchronous, active-low
flush  input  1  discard all entries and any same-cycle push
if_valid  input  1  fetch side presents a word (ROM ce active and data returned)
if_pc  input  ADDR_W  address of presented word
if_inst  input  INST_W  instruction word from ROM
if_ready  output  1  queue can accept a push this cycle
id_valid  output  1  head entry valid for decode
id_pc  output  ADDR_W  head entry address; 0 when id_valid=0
id_inst  output  INST_W  head entry instruction; 0 (nop) when id_valid=0
id_ready  input  1  decode accepts head this cycle (not stalled)
q_count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (rst=0, asserted asynchronously):
  - Read/write pointers and q_count = 0; storage need not be cleared.
  - id_valid=0, id_pc=0, id_inst=0.
  - if_ready forced 0 while rst=0.
- Push occurs on a rising edge when if_valid & if_ready & !flush.
- Pop occurs on a rising edge when id_valid & id_ready & !flush.
- if_ready = (q_count < DEPTH) & rst, computed from registered count only; no combinational path from id_ready.
- When full, a same-cycle pop does not enable a push; the push is refused and fetch must hold and retry.
- id_valid = (q_count != 0); id_pc/id_inst read combinationally from the head entry.
- Latency: a word pushed at edge N is visible at id_* after edge N; one cycle minimum, no bypass by default.
- Occupancy update per edge:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. q_count saturates structurally: never exceeds DEPTH, never underflows.
- Flush has priority over push and pop. At that edge both pointers and q_count reset to 0; id_valid=0 the following cycle.
- if_valid is ignored while if_ready=0.
- Order is strictly FIFO; the entry presented at id_* is stable until popped or flushed.

Optional Feature:
Macro FETCHQ_BYPASS_EN.
- Defined: when q_count=0, if_valid=1, id_ready=1 and flush=0:
  - id_valid=1 and id_pc/id_inst=if_pc/if_inst combinationally in the same cycle.
  - The word is consumed without being written, so q_count stays 0.
  - If q_count=0, if_valid=1 and id_ready=0, the word is pushed normally.
- Undefined: no combinational path from if_* to id_*; minimum latency is one cycle.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with if_valid=1 -> if_ready=0, id_valid=0, id_inst=0, q_count=0; after release, if_ready=1.
2. In-order flow: push pc 0x0, 0x4, 0x8 (inst 0x34011100, 0x34020020, 0x3403ff00) with id_ready=0, then id_ready=1 for 3 cycles -> q_count 1,2,3 during pushes; id_pc then pops 0x0, 0x4, 0x8 in order; q_count returns to 0.
3. Full, DEPTH=4: push 5 consecutive words with id_ready=0 -> if_ready=0 after the 4th; 5th word not stored; q_count=4. Pop one, then push -> 5th word accepted on the retry.
4. Simultaneous push/pop at q_count=2 for 6 cycles -> q_count stays 2; pointers wrap past entry 3 with no loss; output sequence matches input.
5. Flush: 3 entries queued, assert flush together with if_valid=1 and id_ready=1 -> next cycle q_count=0, id_valid=0; flushed-cycle word is absent from all later outputs.
6. Bypass (FETCHQ_BYPASS_EN): empty queue, if_valid=1, id_ready=1, if_pc=0x10 -> id_valid=1, id_pc=0x10 in the same cycle, q_count remains 0. Without the macro: id_valid=1 one cycle later.

Source files
------------

// File: rtl/inst_fetch_q_if.sv
// Fetch-to-decode bundle for inst_fetch_q: push side (if_*), pop side (id_*), flush and occupancy.
// slave is the queue's view; master is the pipeline (fetch + decode) view.
interface inst_fetch_q_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic                     flush;
    logic                     if_valid;
    logic [ADDR_W-1:0]        if_pc;
    logic [INST_W-1:0]        if_inst;
    logic                     if_ready;
    logic                     id_valid;
    logic [ADDR_W-1:0]        id_pc;
    logic [INST_W-1:0]        id_inst;
    logic                     id_ready;
    logic [$clog2(DEPTH):0]   q_count;

    modport slave (
        input  flush, if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst, q_count
    );

    modport master (
        output flush, if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, q_count
    );
endinterface

// File: rtl/inst_fetch_q.sv
// Circular FIFO of {pc, inst} pairs between instruction fetch and decode, with flush.
// Optional same-cycle empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.
module inst_fetch_q #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    inst_fetch_q_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic not_empty;
    logic accept;
    logic bypass;
    logic push;
    logic pop;

    // Acceptance looks only at the registered count, so a full queue refuses a push even if decode pops.
    assign not_empty = (count != '0);
    assign accept    = rst & (count < FULL);

`ifdef FETCHQ_BYPASS_EN
    assign bypass = rst & ~not_empty & bus.if_valid & bus.id_ready & ~bus.flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = bus.if_valid & accept & ~bus.flush & ~bypass;
    assign pop  = not_empty & bus.id_ready & ~bus.flush;

    assign bus.if_ready = accept;
    assign bus.q_count  = count;

    always_comb begin
        bus.id_valid = 1'b0;
        bus.id_pc    = '0;
        bus.id_inst  = '0;
        if (not_empty) begin
            bus.id_valid = 1'b1;
            bus.id_pc    = pc_mem[rd_ptr];
            bus.id_inst  = inst_mem[rd_ptr];
        end else if (bypass) begin
            bus.id_valid = 1'b1;
            bus.id_pc    = bus.if_pc;
            bus.id_inst  = bus.if_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset; entries are only observable once the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= bus.if_pc;
            inst_mem[wr_ptr] <= bus.if_inst;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= FULL);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && count == FULL));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop && count == '0));

endmodule

// File: tb/tb_inst_fetch_q.sv
// Directed, table-driven bench for inst_fetch_q: reset, ordering, full/retry, wrap, flush, bypass.
module tb_inst_fetch_q;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic clk = 1'b0;
    logic rst;

    inst_fetch_q_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    inst_fetch_q #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        if_valid;
        logic [31:0] if_pc;
        logic [31:0] if_inst;
        logic        id_ready;
        logic        exp_if_ready;
        logic        exp_id_valid;
        logic [31:0] exp_id_pc;
        logic [31:0] exp_id_inst;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    function automatic void addVec(input logic f, input logic iv, input logic [31:0] pc,
                                   input logic [31:0] inst, input logic idr, input logic erdy,
                                   input logic evalid, input logic [31:0] epc,
                                   input logic [31:0] einst, input logic [2:0] ecnt);
        vec_t v;
        v.flush = f; v.if_valid = iv; v.if_pc = pc; v.if_inst = inst; v.id_ready = idr;
        v.exp_if_ready = erdy; v.exp_id_valid = evalid; v.exp_id_pc = epc;
        v.exp_id_inst = einst; v.exp_count = ecnt;
        vecs.push_back(v);
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the next rising edge.
    task automatic applyStimulus(input logic f, input logic iv, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic idr);
        @(negedge clk);
        bus.flush    = f;
        bus.if_valid = iv;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
        bus.id_ready = idr;
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic erdy, input logic evalid,
                               input logic [31:0] epc, input logic [31:0] einst,
                               input logic [2:0] ecnt);
        checkField({name, ".if_ready"}, 32'(bus.if_ready), 32'(erdy));
        checkField({name, ".id_valid"}, 32'(bus.id_valid), 32'(evalid));
        checkField({name, ".id_pc"},    bus.id_pc,         epc);
        checkField({name, ".id_inst"},  bus.id_inst,       einst);
        checkField({name, ".q_count"},  32'(bus.q_count),  32'(ecnt));
    endtask

    initial begin
        // In-order flow: three pushes with decode stalled, then three pops.
        addVec(0, 1, 32'h0,   32'h34011100, 0,  1, 0, 32'h0,   32'h0,        3'd0);
        addVec(0, 1, 32'h4,   32'h34020020, 0,  1, 1, 32'h0,   32'h34011100, 3'd1);
        addVec(0, 1, 32'h8,   32'h3403ff00, 0,  1, 1, 32'h0,   32'h34011100, 3'd2);
        addVec(0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h0,   32'h34011100, 3'd3);
        addVec(0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h4,   32'h34020020, 3'd2);
        addVec(0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h8,   32'h3403ff00, 3'd1);
        addVec(0, 0, 32'h0,   32'h0,        0,  1, 0, 32'h0,   32'h0,        3'd0);
        // Full: fifth push refused, held and retried after one pop.
        addVec(0, 1, 32'h100, 32'h24000100, 0,  1, 0, 32'h0,   32'h0,        3'd0);
        addVec(0, 1, 32'h104, 32'h24000104, 0,  1, 1, 32'h100, 32'h24000100, 3'd1);
        addVec(0, 1, 32'h108, 32'h24000108, 0,  1, 1, 32'h100, 32'h24000100, 3'd2);
        addVec(0, 1, 32'h10c, 32'h2400010c, 0,  1, 1, 32'h100, 32'h24000100, 3'd3);
        addVec(0, 1, 32'h110, 32'h24000110, 0,  0, 1, 32'h100, 32'h24000100, 3'd4);
        addVec(0, 1, 32'h110, 32'h24000110, 1,  0, 1, 32'h100, 32'h24000100, 3'd4);
        addVec(0, 1, 32'h110, 32'h24000110, 0,  1, 1, 32'h104, 32'h24000104, 3'd3);
        addVec(0, 0, 32'h0,   32'h0,        1,  0, 1, 32'h104, 32'h24000104, 3'd4);
        addVec(0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h108, 32'h24000108, 3'd3);
        // Simultaneous push/pop at occupancy 2; pointers wrap repeatedly.
        addVec(0, 1, 32'h200, 32'h24000200, 1,  1, 1, 32'h10c, 32'h2400010c, 3'd2);
        addVec(0, 1, 32'h204, 32'h24000204, 1,  1, 1, 32'h110, 32'h24000110, 3'd2);
        addVec(0, 1, 32'h208, 32'h24000208, 1,  1, 1, 32'h200, 32'h24000200, 3'd2);
        addVec(0, 1, 32'h20c, 32'h2400020c, 1,  1, 1, 32'h204, 32'h24000204, 3'd2);
        addVec(0, 1, 32'h210, 32'h24000210, 1,  1, 1, 32'h208, 32'h24000208, 3'd2);
        addVec(0, 1, 32'h214, 32'h24000214, 1,  1, 1, 32'h20c, 32'h2400020c, 3'd2);
        addVec(0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h210, 32'h24000210, 3'd2);
        addVec(0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h214, 32'h24000214, 3'd1);
        addVec(0, 0, 32'h0,   32'h0,        0,  1, 0, 32'h0,   32'h0,        3'd0);

        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_inst  = '0;
        bus.id_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h40, 32'h34010040, 0);
            checkOutput($sformatf("reset%0d", i), 0, 0, 32'h0, 32'h0, 3'd0);
        end
        @(negedge clk);
        rst          = 1'b1;
        bus.if_valid = 1'b0;
        #1;
        checkOutput("reset_release", 1, 0, 32'h0, 32'h0, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].flush, vecs[i].if_valid, vecs[i].if_pc, vecs[i].if_inst,
                          vecs[i].id_ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_if_ready, vecs[i].exp_id_valid,
                        vecs[i].exp_id_pc, vecs[i].exp_id_inst, vecs[i].exp_count);
        end

        // Flush with a simultaneous push and pop; neither may take effect.
        applyStimulus(0, 1, 32'h300, 32'h24000300, 0);
        checkOutput("flush_fill0", 1, 0, 32'h0, 32'h0, 3'd0);
        applyStimulus(0, 1, 32'h304, 32'h24000304, 0);
        checkOutput("flush_fill1", 1, 1, 32'h300, 32'h24000300, 3'd1);
        applyStimulus(0, 1, 32'h308, 32'h24000308, 0);
        checkOutput("flush_fill2", 1, 1, 32'h300, 32'h24000300, 3'd2);
        applyStimulus(1, 1, 32'h30c, 32'h2400030c, 1);
        checkOutput("flush_edge", 1, 1, 32'h300, 32'h24000300, 3'd3);
        applyStimulus(0, 0, 32'h0, 32'h0, 1);
        checkOutput("flush_after", 1, 0, 32'h0, 32'h0, 3'd0);
        applyStimulus(0, 1, 32'h400, 32'h24000400, 0);
        checkOutput("flush_refill", 1, 0, 32'h0, 32'h0, 3'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        checkOutput("flush_head", 1, 1, 32'h400, 32'h24000400, 3'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 1);
        checkOutput("flush_pop", 1, 1, 32'h400, 32'h24000400, 3'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        checkOutput("flush_empty", 1, 0, 32'h0, 32'h0, 3'd0);

        // Empty queue, fetch and decode both ready in the same cycle.
        applyStimulus(0, 1, 32'h10, 32'h3c1d0010, 1);
`ifdef FETCHQ_BYPASS_EN
        checkOutput("bypass_same", 1, 1, 32'h10, 32'h3c1d0010, 3'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        checkOutput("bypass_after", 1, 0, 32'h0, 32'h0, 3'd0);
`else
        checkOutput("bypass_same", 1, 0, 32'h0, 32'h0, 3'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        checkOutput("bypass_next", 1, 1, 32'h10, 32'h3c1d0010, 3'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 1);
        checkOutput("bypass_pop", 1, 1, 32'h10, 32'h3c1d0010, 3'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        checkOutput("bypass_empty", 1, 0, 32'h0, 32'h0, 3'd0);
`endif

        // Asynchronous reset asserted between clock edges with entries queued.
        applyStimulus(0, 1, 32'h500, 32'h24000500, 0);
        applyStimulus(0, 1, 32'h504, 32'h24000504, 0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        checkOutput("areset_pre", 1, 1, 32'h500, 32'h24000500, 3'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("areset_now", 0, 0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("areset_release", 1, 0, 32'h0, 32'h0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
